// File: rtl/aes_out_serializer.sv
// ---------------------------------------------------------------------------
// aes_out_serializer
//
// Output stage for the AES-128 core. Each 128-bit ciphertext block is
// captured on the core's one-cycle aes_valid strobe into a DEPTH-entry block
// FIFO. Blocks are then sent as four 32-bit words, most significant word
// first, over a valid/ready stream.
//
// Stream handshake: a word moves on every rising edge where
// m_valid & m_ready. While m_valid=1 and m_ready=0, m_data and m_last hold.
// m_valid only drops after a transfer, or on reset.
//
// The core cannot be stalled. If a block arrives while every slot is full
// and no pop happens on the same edge, the block is dropped. The sticky
// overflow flag is then set, and the FIFO contents stay unchanged.
//
// Optional feature (macro AES_OUT_BLOCK_CNT_EN): adds a 16-bit block_cnt
// output. It counts completed blocks (pops) and wraps at 16'hFFFF.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   aes_out_bus  in   [127:0] ciphertext, meaningful while aes_valid=1
//   aes_valid    in   core output strobe
//   m_data       out  [31:0] current output word (0 while m_valid=0)
//   m_valid      out  m_data holds a valid word
//   m_ready      in   consumer ready
//   m_last       out  current word is word 3 of its block
//   fifo_level   out  [LVL_W-1:0] occupied block slots, 0..DEPTH
//   overflow     out  sticky: a block was dropped
//   block_cnt    out  [15:0] popped blocks (only with AES_OUT_BLOCK_CNT_EN)
// ---------------------------------------------------------------------------
module aes_out_serializer #(
    parameter int DEPTH = 2,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     aes_out_bus,
    input  logic             aes_valid,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [LVL_W-1:0] fifo_level,
`ifdef AES_OUT_BLOCK_CNT_EN
    output logic [15:0]      block_cnt,
`endif
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Block storage. It has no reset: the occupancy counter gates every read.
    logic [127:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic [1:0]       r_word_idx;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_xfer;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [127:0]     w_head;
    logic [31:0]      w_word;

    assign w_full  = (r_count == LVL_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_xfer  = !w_empty && m_ready;
    assign w_pop   = w_xfer && (r_word_idx == 2'd3);
    // A pop on the same edge frees the head slot, so a push into a full FIFO
    // is still accepted when the last word of the head block leaves.
    assign w_push  = aes_valid && (!w_full || w_pop);
    assign w_drop  = aes_valid && !w_push;

    assign w_head = r_mem[r_rd_ptr];

    // The first word sent is the most significant word (AES state byte 0 first).
    always_comb begin
        w_word = 32'd0;
        case (r_word_idx)
            2'd0: w_word = w_head[127:96];
            2'd1: w_word = w_head[95:64];
            2'd2: w_word = w_head[63:32];
            2'd3: w_word = w_head[31:0];
            default: w_word = 32'd0;
        endcase
    end

    assign m_valid    = !w_empty;
    assign m_data     = w_empty ? 32'd0 : w_word;
    assign m_last     = !w_empty && (r_word_idx == 2'd3);
    assign fifo_level = r_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= aes_out_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word_idx <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_xfer) begin
                r_word_idx <= r_word_idx + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - LVL_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef AES_OUT_BLOCK_CNT_EN
    logic [15:0] r_block_cnt;

    // Only popped blocks are counted. Dropped blocks never reach the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block_cnt <= 16'd0;
        end else if (w_pop) begin
            r_block_cnt <= r_block_cnt + 16'd1;
        end
    end

    assign block_cnt = r_block_cnt;
`endif

endmodule
